// File: rtl/word_hasher_if.sv
// Character-in / hash-out bundle between the tokenizer source and word_hasher.
// Latency: none (wires only).
// Backpressure: none; the source may present one character every cycle.
interface word_hasher_if #(
    parameter int LEN_W = 5
);
    logic [7:0]       char_in;
    logic             char_valid;
    logic             flush;
    logic [9:0]       hash1;
    logic [9:0]       hash2;
    logic [LEN_W-1:0] word_len;
    logic             hash_ready;
    logic             overflow;

    // Character source side.
    modport master (
        output char_in, char_valid, flush,
        input  hash1, hash2, word_len, hash_ready, overflow
    );

    // Hasher side.
    modport slave (
        input  char_in, char_valid, flush,
        output hash1, hash2, word_len, hash_ready, overflow
    );
endinterface

// File: rtl/word_hasher.sv
// Splits a byte stream into case-folded words and computes two 10-bit hashes per word.
// Latency: 1 cycle from the terminating delimiter/flush to the hash_ready/overflow strobe.
// Backpressure: none; accepts one character per cycle, downstream must take every strobe.
module word_hasher #(
    parameter int         MAX_LEN = 16,
    parameter int         LEN_W   = 5,
    parameter logic [9:0] H2_SEED = 10'h155
) (
    input  logic          clk,
    input  logic          rst_n,
    word_hasher_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_IN_WORD,
        S_OVERFLOW
    } state_t;

    localparam logic [7:0] APOSTROPHE = 8'h27;

    state_t           state;
    state_t           state_next;

    logic [9:0]       acc1;
    logic [9:0]       acc2;
    logic [LEN_W-1:0] len;

    logic             is_upper;
    logic             is_lower;
    logic             letter_vld;
    logic             delim_vld;
    logic             term;
    logic [7:0]       letter_c;
    logic [9:0]       acc1_upd;
    logic [9:0]       acc2_upd;
    logic             take;
    logic             ovf_letter;
    logic [9:0]       acc1_next;
    logic [9:0]       acc2_next;
    logic [LEN_W-1:0] len_next;
    logic             do_emit;
    logic             do_ovf;

    // Classify the incoming byte, fold case and precompute the accumulator updates.
    always_comb begin
        is_upper   = (bus.char_in >= 8'h41) && (bus.char_in <= 8'h5A);
        is_lower   = (bus.char_in >= 8'h61) && (bus.char_in <= 8'h7A);
        letter_vld = bus.char_valid && (is_upper || is_lower);
        // Apostrophes are neither letters nor delimiters: "don't" hashes as "dont".
        delim_vld  = bus.char_valid && !(is_upper || is_lower) && (bus.char_in != APOSTROPHE);
        term       = delim_vld || bus.flush;
        letter_c   = is_upper ? (bus.char_in + 8'h20) : bus.char_in;
        // acc1*31 computed as acc1*32 - acc1; 10-bit wraparound gives the mod 1024.
        acc1_upd   = (acc1 << 5) - acc1 + {2'b00, letter_c};
        acc2_upd   = {acc2[6:0], acc2[9:7]} ^ {2'b00, letter_c};

        take       = letter_vld &&
                     ((state == S_IDLE) ||
                      ((state == S_IN_WORD) && (len < LEN_W'(MAX_LEN))));
        ovf_letter = letter_vld && (state == S_IN_WORD) && (len >= LEN_W'(MAX_LEN));

        // A letter arriving with flush is folded in before the word is emitted.
        acc1_next  = take ? acc1_upd : acc1;
        acc2_next  = take ? acc2_upd : acc2;
        len_next   = take ? (len + LEN_W'(1)) : len;
    end

    // Next-state and strobe decode.
    always_comb begin
        state_next = state;
        do_emit    = 1'b0;
        do_ovf     = 1'b0;
        case (state)
            S_IDLE: begin
                if (take) begin
                    if (bus.flush) begin
                        do_emit = 1'b1;
                    end else begin
                        state_next = S_IN_WORD;
                    end
                end
            end
            S_IN_WORD: begin
                if (ovf_letter) begin
                    if (bus.flush) begin
                        do_ovf     = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        state_next = S_OVERFLOW;
                    end
                end else if (term) begin
                    do_emit    = 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_OVERFLOW: begin
                if (term) begin
                    do_ovf     = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Accumulators; reinitialised on the terminating edge so the next word starts cleanly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc1 <= 10'd0;
            acc2 <= H2_SEED;
            len  <= '0;
        end else if (do_emit || do_ovf) begin
            acc1 <= 10'd0;
            acc2 <= H2_SEED;
            len  <= '0;
        end else if (take) begin
            acc1 <= acc1_upd;
            acc2 <= acc2_upd;
            len  <= len_next;
        end
    end

    // Output registers: strobes last one cycle, hashes hold until the next emit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.hash1      <= 10'd0;
            bus.hash2      <= 10'd0;
            bus.word_len   <= '0;
            bus.hash_ready <= 1'b0;
            bus.overflow   <= 1'b0;
        end else begin
            bus.hash_ready <= do_emit;
            bus.overflow   <= do_ovf;
            if (do_emit) begin
                bus.hash1    <= acc1_next;
                bus.hash2    <= acc2_next;
                bus.word_len <= len_next;
            end
        end
    end

endmodule

// File: tb/tb_word_hasher.sv
// Self-checking bench for word_hasher: directed vectors plus a randomized word stream.
// Latency: expects strobes one cycle after the terminating character.
// Backpressure: none; the bench drives one character per cycle.
module tb_word_hasher;

    localparam int MAX_LEN = 16;
    localparam int LEN_W   = 5;

    logic clk;
    logic rst_n;

    word_hasher_if #(.LEN_W(LEN_W)) bus ();

    word_hasher #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W),
        .H2_SEED (10'h155)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int nrdy  = 0;
    int novf  = 0;

    // Word-level reference model: collect folded letters, hash the whole word at its end.
    byte unsigned     model_q[$];
    logic             exp_rdy;
    logic             exp_ovf;
    logic [9:0]       exp_h1;
    logic [9:0]       exp_h2;
    logic [LEN_W-1:0] exp_len;

    task automatic model_reset();
        model_q.delete();
        exp_rdy = 1'b0;
        exp_ovf = 1'b0;
        exp_h1  = 10'd0;
        exp_h2  = 10'd0;
        exp_len = '0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] c, input logic f);
        int  h1;
        int  h2;
        bit  letter;
        bit  term;
        letter  = v && (((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A)));
        term    = f || (v && !letter && (c != 8'h27));
        exp_rdy = 1'b0;
        exp_ovf = 1'b0;
        if (letter) model_q.push_back((c <= 8'h5A) ? c + 8'd32 : c);
        if (term && model_q.size() > 0) begin
            if (model_q.size() > MAX_LEN) begin
                exp_ovf = 1'b1;
            end else begin
                h1 = 0;
                h2 = 'h155;
                foreach (model_q[i]) begin
                    h1 = (h1 * 31 + model_q[i]) % 1024;
                    h2 = (((h2 << 3) | (h2 >> 7)) & 1023) ^ model_q[i];
                end
                exp_rdy = 1'b1;
                exp_h1  = h1[9:0];
                exp_h2  = h2[9:0];
                exp_len = LEN_W'(model_q.size());
            end
        end
        if (term) model_q.delete();
    endtask

    // Drive one cycle of input, then look just after the edge.
    task automatic drive(input logic v, input logic [7:0] c, input logic f);
        bus.char_valid = v;
        bus.char_in    = c;
        bus.flush      = f;
        @(posedge clk);
        #1;
        model_step(v, c, f);
        if (bus.hash_ready === 1'b1) nrdy++;
        if (bus.overflow === 1'b1) novf++;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) drive(1'b1, s[i], 1'b0);
    endtask

    task automatic test_reset();
        bus.char_valid = 1'b0;
        bus.char_in    = 8'h00;
        bus.flush      = 1'b0;
        rst_n          = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.hash1 !== 10'd0) begin bad++; $display("FAIL reset_hash1 got=%0d want=0", bus.hash1); end
        total++; if (bus.hash2 !== 10'd0) begin bad++; $display("FAIL reset_hash2 got=%0d want=0", bus.hash2); end
        total++; if (bus.word_len !== '0) begin bad++; $display("FAIL reset_len got=%0d want=0", bus.word_len); end
        total++; if (bus.hash_ready !== 1'b0) begin bad++; $display("FAIL reset_rdy got=%b want=0", bus.hash_ready); end
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", bus.overflow); end
        rst_n = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_the();
        nrdy = 0;
        send_str("the ");
        total++; if (bus.hash_ready !== 1'b1) begin bad++; $display("FAIL the_rdy got=%b want=1", bus.hash_ready); end
        total++; if (nrdy != 1) begin bad++; $display("FAIL the_strobes got=%0d want=1", nrdy); end
        total++; if (bus.hash1 !== 10'd113) begin bad++; $display("FAIL the_hash1 got=%0d want=113", bus.hash1); end
        total++; if (bus.hash2 !== 10'd136) begin bad++; $display("FAIL the_hash2 got=%0d want=136", bus.hash2); end
        total++; if (bus.word_len !== 5'd3) begin bad++; $display("FAIL the_len got=%0d want=3", bus.word_len); end
        drive(1'b0, 8'h00, 1'b0);
        total++; if (bus.hash_ready !== 1'b0) begin bad++; $display("FAIL the_rdy_drop got=%b want=0", bus.hash_ready); end
        total++; if (bus.hash1 !== 10'd113) begin bad++; $display("FAIL the_hold got=%0d want=113", bus.hash1); end
    endtask

    task automatic test_case_fold();
        send_str("THE ");
        total++; if ({bus.hash_ready, bus.hash1, bus.hash2, bus.word_len} !== {1'b1, 10'd113, 10'd136, 5'd3}) begin
            bad++; $display("FAIL upper_the got=%b/%0d/%0d/%0d want=1/113/136/3", bus.hash_ready, bus.hash1, bus.hash2, bus.word_len);
        end
        send_str("t'he ");
        total++; if ({bus.hash_ready, bus.hash1, bus.hash2, bus.word_len} !== {1'b1, 10'd113, 10'd136, 5'd3}) begin
            bad++; $display("FAIL apos_the got=%b/%0d/%0d/%0d want=1/113/136/3", bus.hash_ready, bus.hash1, bus.hash2, bus.word_len);
        end
        drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_spaces();
        nrdy = 0;
        send_str("  a  ");
        drive(1'b0, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b0);
        total++; if (nrdy != 1) begin bad++; $display("FAIL spaces_strobes got=%0d want=1", nrdy); end
        total++; if (bus.hash1 !== 10'd97) begin bad++; $display("FAIL a_hash1 got=%0d want=97", bus.hash1); end
        total++; if (bus.hash2 !== 10'h2CB) begin bad++; $display("FAIL a_hash2 got=%h want=2cb", bus.hash2); end
        total++; if (bus.word_len !== 5'd1) begin bad++; $display("FAIL a_len got=%0d want=1", bus.word_len); end
    endtask

    task automatic test_overflow();
        // Exactly MAX_LEN letters is still a legal word.
        nrdy = 0;
        send_str("abcdefghijklmnop ");
        total++; if (bus.hash_ready !== 1'b1 || bus.word_len !== 5'd16) begin
            bad++; $display("FAIL max_len got=%b/%0d want=1/16", bus.hash_ready, bus.word_len);
        end
        total++; if (bus.hash1 !== exp_h1 || bus.hash2 !== exp_h2) begin
            bad++; $display("FAIL max_len_hash got=%0d/%0d want=%0d/%0d", bus.hash1, bus.hash2, exp_h1, exp_h2);
        end
        nrdy = 0;
        novf = 0;
        send_str("qqqqqqqqqqqqqqqqq ");
        total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_strobe got=%b want=1", bus.overflow); end
        drive(1'b0, 8'h00, 1'b0);
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL ovf_drop got=%b want=0", bus.overflow); end
        total++; if (nrdy != 0 || novf != 1) begin bad++; $display("FAIL ovf_counts got=%0d/%0d want=0/1", nrdy, novf); end
        total++; if (bus.word_len !== 5'd16) begin bad++; $display("FAIL ovf_hold got=%0d want=16", bus.word_len); end
        send_str("the ");
        total++; if ({bus.hash_ready, bus.hash1, bus.hash2} !== {1'b1, 10'd113, 10'd136}) begin
            bad++; $display("FAIL after_ovf got=%b/%0d/%0d want=1/113/136", bus.hash_ready, bus.hash1, bus.hash2);
        end
        drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_flush_letter();
        nrdy = 0;
        send_str("th");
        drive(1'b1, 8'h65, 1'b1);
        total++; if ({bus.hash_ready, bus.hash1, bus.hash2, bus.word_len} !== {1'b1, 10'd113, 10'd136, 5'd3}) begin
            bad++; $display("FAIL flush_letter got=%b/%0d/%0d/%0d want=1/113/136/3", bus.hash_ready, bus.hash1, bus.hash2, bus.word_len);
        end
        drive(1'b0, 8'h00, 1'b0);
        total++; if (nrdy != 1) begin bad++; $display("FAIL flush_letter_strobes got=%0d want=1", nrdy); end
    endtask

    task automatic test_reset_mid();
        nrdy = 0;
        send_str("the");
        bus.char_valid = 1'b0;
        rst_n          = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
        send_str(" ");
        drive(1'b0, 8'h00, 1'b0);
        total++; if (nrdy != 0) begin bad++; $display("FAIL rst_mid_strobes got=%0d want=0", nrdy); end
        total++; if ({bus.hash1, bus.hash2, bus.word_len} !== 25'd0) begin
            bad++; $display("FAIL rst_mid_outputs got=%0d/%0d/%0d want=0/0/0", bus.hash1, bus.hash2, bus.word_len);
        end
    endtask

    task automatic test_back_to_back();
        nrdy = 0;
        send_str("ab ");
        total++; if ({bus.hash_ready, bus.hash1, bus.hash2, bus.word_len} !== {exp_rdy, exp_h1, exp_h2, exp_len}) begin
            bad++; $display("FAIL b2b_first got=%b/%0d/%0d/%0d want=%b/%0d/%0d/%0d", bus.hash_ready, bus.hash1,
                bus.hash2, bus.word_len, exp_rdy, exp_h1, exp_h2, exp_len);
        end
        send_str("x");
        total++; if (bus.hash_ready !== 1'b0) begin bad++; $display("FAIL b2b_gap got=%b want=0", bus.hash_ready); end
        send_str(" ");
        total++; if ({bus.hash_ready, bus.hash1, bus.hash2, bus.word_len} !== {1'b1, 10'd120, 10'h2D2, 5'd1}) begin
            bad++; $display("FAIL b2b_second got=%b/%0d/%0d/%0d want=1/120/722/1", bus.hash_ready, bus.hash1, bus.hash2, bus.word_len);
        end
        drive(1'b0, 8'h00, 1'b0);
        total++; if (nrdy != 2) begin bad++; $display("FAIL b2b_strobes got=%0d want=2", nrdy); end
    endtask

    task automatic test_random();
        logic       sv[$];
        logic [7:0] sc[$];
        logic       sf[$];
        int         wlen;
        int         kind;
        byte unsigned ch;
        for (int w = 0; w < 200; w++) begin
            wlen = $urandom_range(0, 19);
            kind = $urandom_range(0, 3);
            for (int i = 0; i < wlen; i++) begin
                if ($urandom_range(0, 9) == 0) begin sv.push_back(1'b1); sc.push_back(8'h27); sf.push_back(1'b0); end
                if ($urandom_range(0, 9) == 0) begin sv.push_back(1'b0); sc.push_back(8'($urandom_range(0, 255))); sf.push_back(1'b0); end
                ch = 8'($urandom_range(0, 25)) + (($urandom_range(0, 1) == 1) ? 8'h41 : 8'h61);
                sv.push_back(1'b1);
                sc.push_back(ch);
                sf.push_back((kind == 3) && (i == wlen - 1));
            end
            case (kind)
                0: begin sv.push_back(1'b1); sc.push_back(8'h20); sf.push_back(1'b0); end
                1: begin sv.push_back(1'b0); sc.push_back(8'($urandom_range(0, 255))); sf.push_back(1'b1); end
                2: begin sv.push_back(1'b1); sc.push_back(8'h30 + 8'($urandom_range(0, 9))); sf.push_back($urandom_range(0, 1) == 1); end
                default: begin end
            endcase
        end
        for (int i = 0; i < sv.size(); i++) begin
            drive(sv[i], sc[i], sf[i]);
            total++; if (bus.hash_ready !== exp_rdy) begin bad++; $display("FAIL rnd_rdy cyc=%0d got=%b want=%b", i, bus.hash_ready, exp_rdy); end
            total++; if (bus.overflow !== exp_ovf) begin bad++; $display("FAIL rnd_ovf cyc=%0d got=%b want=%b", i, bus.overflow, exp_ovf); end
            total++; if ({bus.hash1, bus.hash2, bus.word_len} !== {exp_h1, exp_h2, exp_len}) begin
                bad++; $display("FAIL rnd_hash cyc=%0d got=%0d/%0d/%0d want=%0d/%0d/%0d", i, bus.hash1, bus.hash2,
                    bus.word_len, exp_h1, exp_h2, exp_len);
            end
        end
        drive(1'b0, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        test_reset();
        test_the();
        test_case_fold();
        test_spaces();
        test_overflow();
        test_flush_letter();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/word_hasher.md
Name: word_hasher

Overview:
- Upstream stage of the Bloom-filter lookup in the censor IP.
- Consumes a character stream one byte per cycle, splits it into words, and case-folds letters.
- Computes two independent 10-bit hashes per word.
- Presents them with a one-cycle hash_ready strobe to the Bloom table lookup, which evaluates is_bad_word combinationally during that strobe.

Parameters:
- MAX_LEN, 16: longest word (letters) that is hashed; longer words are discarded.
- LEN_W, 5: width of word_len; must satisfy 2**LEN_W > MAX_LEN.
- H2_SEED, 10'h155: initial value of the hash2 accumulator.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- char_in  input  8  ASCII character.
- char_valid  input  1  char_in is consumed this cycle.
- flush  input  1  end of stream; terminates any word in progress.
- hash1  output  10  word hash 1, registered.
- hash2  output  10  word hash 2, registered.
- word_len  output  LEN_W  letter count of the emitted word, registered.
- hash_ready  output  1  one-cycle strobe; hash1/hash2/word_len are valid.
- overflow  output  1  one-cycle strobe; a word exceeding MAX_LEN was dropped.

Behaviour:
- Reset (async assert, sync release):
  - hash1 = 0, hash2 = 0, word_len = 0, hash_ready = 0, overflow = 0.
  - Accumulators: acc1 = 0, acc2 = H2_SEED, len = 0; state IDLE.
- Character classes:
  - Letter: 'a'-'z', or 'A'-'Z' folded to lowercase (add 8'h20) before hashing.
  - Apostrophe (8'h27): ignored, no state change ("don't" hashes as "dont").
  - Everything else is a delimiter.
- Hash update per accepted letter c (8-bit, zero-extended to 10 bits):
  - acc1 <= (acc1*31 + c) mod 1024.
  - acc2 <= {acc2[6:0], acc2[9:7]} XOR c (rotate left by 3, then XOR).
  - len <= len + 1.
- States:
  - IDLE: letter -> IN_WORD (accumulate). Delimiter/apostrophe -> stay, no output.
  - IN_WORD, letter with len < MAX_LEN: accumulate, stay.
  - IN_WORD, letter with len == MAX_LEN: -> OVERFLOW.
  - IN_WORD, delimiter or flush: emit, -> IDLE.
  - OVERFLOW: letters ignored. Delimiter or flush: overflow = 1 next cycle, no hash_ready, accumulators reinitialised, -> IDLE.
- Emit:
  - In the cycle after the terminating delimiter/flush, hash_ready = 1 for exactly one cycle.
  - hash1 = acc1, hash2 = acc2, word_len = len, all captured from the final accumulators.
  - Accumulators reinitialise in the same edge, so a letter arriving in the hash_ready cycle starts a new word without loss.
- Hold: hash1/hash2/word_len hold their last emitted values until the next emit. They are never cleared except by reset.
- Empty words: consecutive delimiters, or flush in IDLE, produce no strobe.
- Simultaneous events:
  - flush together with a valid delimiter: single emit.
  - flush together with a valid letter: the letter is accumulated first, then the word is emitted including it.
- char_valid = 0: no state change; flush still acts.
- Latency: 1 cycle from the terminating event to hash_ready. Throughput: 1 char/cycle, no backpressure.
- Reset mid-word: partial word discarded, no strobe after release.

Test Plan:
- "the " (t,h,e,space, back-to-back) -> one cycle after the space: hash_ready = 1, hash1 = 113, hash2 = 10'h088 (136), word_len = 3.
- "THE " -> identical outputs to "the ". "t'he " -> identical outputs and word_len = 3.
- "  a  " with extra spaces, then flush in IDLE -> exactly one hash_ready (for "a": hash1 = 97, hash2 = 10'h2AA^97 = 10'h2CB, word_len = 1).
- 17 letters then space, MAX_LEN = 16 -> no hash_ready; overflow = 1 for one cycle; a following "the " emits 113/136 correctly.
- "the" followed by flush asserted together with char_valid on 'e' -> single hash_ready next cycle with 113/136.
- "the" then rst_n low for 1 cycle, then " " -> no strobe, outputs 0; "x " letter in the hash_ready cycle of a prior word -> both words emitted.
